// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer multiplexer / demultiplexer pair:
// word format, port count and the round-robin port helper.
package buffer_pkg;

   localparam int DATA_W    = 35;
   localparam int MULTI_BIT = DATA_W - 1;
   localparam int NUM_PORTS = 4;

   localparam logic [DATA_W-1:0] IDLE_WORD = '0;

   typedef logic [1:0] port_idx_t;

   // Next port in round-robin order; wraps 3 -> 0 through the 2-bit width.
   function automatic port_idx_t next_port(input port_idx_t p);
      return p + 2'd1;
   endfunction

endpackage

// File: rtl/buffer_demux.sv
// 1-to-4 word distributor. Upstream words pass through a single holding
// register and are dealt round-robin to four downstream buffers. Words with
// the multiwidth flag set keep the current port so a whole group lands on
// one buffer; a group longer than MAX_BURST is cut and flagged on burst_err.
module buffer_demux
   import buffer_pkg::*;
#(
   parameter int DATA_W    = buffer_pkg::DATA_W,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              ready0,
   input  logic              ready1,
   input  logic              ready2,
   input  logic              ready3,
   output logic [DATA_W-1:0] out_data0,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [DATA_W-1:0] out_data3,
   output logic              burst_err
);

   localparam int               CNT_W    = $clog2(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   logic [DATA_W-1:0]                hold_q, hold_d;
   logic                             hold_valid_q, hold_valid_d;
   port_idx_t                        sel_q, sel_d;
   logic [CNT_W-1:0]                 burst_cnt_q, burst_cnt_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0] out_q, out_d;
   logic                             burst_err_q, burst_err_d;

   logic [NUM_PORTS-1:0] ready_s;
   logic                 sel_ready_s;
   logic                 drain_s;
   logic                 capture_s;

   assign ready_s     = {ready3, ready2, ready1, ready0};
   assign sel_ready_s = ready_s[sel_q];

   // The holding register frees up on the same edge it drains, so a ready
   // destination sustains one word per cycle.
   assign in_ready  = reset & (~hold_valid_q | sel_ready_s);
   assign capture_s = in_ready & (in_data != IDLE_WORD);
   assign drain_s   = hold_valid_q & sel_ready_s;

   assign out_data0 = out_q[0];
   assign out_data1 = out_q[1];
   assign out_data2 = out_q[2];
   assign out_data3 = out_q[3];
   assign burst_err = burst_err_q;

   // Next-state: drain the held word to the selected port, advance the port
   // pointer at group boundaries, and refill the holding register.
   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      sel_d        = sel_q;
      burst_cnt_d  = burst_cnt_q;
      out_d        = '0;
      burst_err_d  = 1'b0;

      if (drain_s) begin
         out_d[sel_q] = hold_q;
         if (!hold_q[DATA_W-1]) begin
            // Single word or last word of a group: move to the next buffer.
            sel_d       = next_port(sel_q);
            burst_cnt_d = '0;
         end else if (burst_cnt_q == CNT_LAST) begin
            // Group reached the size limit: force the advance and flag it.
            sel_d       = next_port(sel_q);
            burst_cnt_d = '0;
            burst_err_d = 1'b1;
         end else begin
            burst_cnt_d = burst_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         sel_d       = sel_q;
         burst_cnt_d = burst_cnt_q;
      end

      if (capture_s) begin
         hold_d       = in_data;
         hold_valid_d = 1'b1;
      end else if (drain_s) begin
         hold_valid_d = 1'b0;
      end else begin
         hold_valid_d = hold_valid_q;
      end
   end

   // State and output registers with synchronous active-low reset; a reset
   // discards any held word without emitting it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         sel_q        <= 2'd0;
         burst_cnt_q  <= '0;
         out_q        <= '0;
         burst_err_q  <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         sel_q        <= sel_d;
         burst_cnt_q  <= burst_cnt_d;
         out_q        <= out_d;
         burst_err_q  <= burst_err_d;
      end
   end

endmodule

// File: doc/buffer_demux.md
Name: buffer_demux

Overview:
- 1-to-4 distributor; the transmit-side counterpart of the 4-to-1 buffer multiplexer. Same 35-bit word format: an all-zero word means idle, and bit 34 is the multiwidth/continuation flag.
- Takes one upstream word stream and deals words round-robin to four downstream buffers (port 0,1,2,3,0,...).
- Keeps each multiwidth group on one port, so the multiplexer at the far end reassembles the original order.

Parameters:
- DATA_W, 35, word width; bit DATA_W-1 is the multiwidth flag.
- MAX_BURST, 8, maximum words per multiwidth group before the port is forced to advance (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_data  in  DATA_W  upstream word; zero = no data.
- in_ready  out  1  block can capture in_data on this edge.
- ready0..ready3  in  1 each  downstream buffer N can accept a word this cycle.
- out_data0..out_data3  out  DATA_W each  word to buffer N; zero when not sending.
- burst_err  out  1  one-cycle pulse when a group is truncated at MAX_BURST.

Behaviour:
- State registers:
  - hold[DATA_W-1:0], hold_valid: 1-entry holding register.
  - sel[1:0]: current destination port.
  - burst_cnt: $clog2(MAX_BURST) bits.
  - out_data0..3 and burst_err: registered.
- Reset (reset==0 at an edge):
  - out_data0..3=0, burst_err=0, hold=0, hold_valid=0, sel=0, burst_cnt=0.
  - in_ready=0 while reset is low.
  - Reset mid-operation discards any held word; nothing is emitted for it.
- in_ready (combinational) = reset && (!hold_valid || ready[sel]). This gives full throughput, one word per cycle, when the destination is ready.
- Capture: on an edge with in_ready==1 and in_data!=0, hold<=in_data and hold_valid<=1.
  - in_data!=0 while in_ready==0 is not captured; upstream must hold the word until it sees in_ready.
  - Zero words are never captured.
- Drain: on an edge with hold_valid==1 and ready[sel]==1:
  - out_data[sel]<=hold for exactly one cycle.
  - hold_valid<=0, unless a capture occurs on the same edge, in which case it stays 1 with the new word.
- Port advance, evaluated at drain:
  - If hold[DATA_W-1]==0: sel<=sel+1 (wraps 3->0), burst_cnt<=0.
  - Else if burst_cnt==MAX_BURST-1: sel<=sel+1, burst_cnt<=0, burst_err<=1 for one cycle.
  - Else: burst_cnt<=burst_cnt+1 and sel is unchanged.
- Latency: in_data captured at edge k appears on out_data[sel] after edge k+1 if ready[sel] is high in cycle k+1. Otherwise it is held indefinitely (strict order, no skipping).
- Non-selected out_data ports are 0 every cycle. At most one out_data is nonzero in any cycle.
- A word captured on the same edge as a drain is routed to the post-advance sel.
- If ready[sel] drops while hold_valid, hold and sel are frozen and in_ready=0.
- burst_cnt never exceeds MAX_BURST-1.

Decomposition:
- Shared package buffer_pkg, also imported by the multiplexer:
  - DATA_W=35, MULTI_BIT=DATA_W-1, NUM_PORTS=4, IDLE_WORD='0.
  - Port index type: 2-bit.
- No sub-module. The hold register, pointer and counter are small enough to stay in one module.

Test Plan:
- Reset, then all ready=1 and words 0x001,0x002,0x003,0x004,0x005 on consecutive edges -> one-cycle pulses on out_data0..3 then out_data0, each one cycle after capture; in_ready stays 1.
- Multiwidth: words 0x400000001, 0x400000002, 0x000000003 (bit34 set on the first two) then 0x004 -> first three on out_data0, 0x004 on out_data1; burst_err stays 0.
- Backpressure: ready1=0 with sel=1 and hold=0x0AA -> in_ready=0, and out_data1 stays 0 until ready1=1. One cycle after ready1 rises, out_data1=0x0AA; a new word presented in that cycle is captured.
- MAX_BURST=8: nine words, all with bit34 set -> first eight on out_data0, burst_err pulses with the eighth, ninth goes to out_data1.
- Idle gaps: zero words interleaved -> no capture and no outputs for those cycles; sel does not advance on idle.
- Reset asserted while hold_valid with ready0=0 -> after release, sel=0, all outputs 0, held word never emitted, in_ready=1.
